seg7_scan2: RTL and testbench
=============================

# seg7_scan2

Time-multiplexed two-digit seven-segment display driver: the consumer end of the team's two-digit BCD counter outputs (ones digit, tens digit). It snapshots both BCD digits atomically once per scan frame, alternately enables each digit with its decoded segment pattern, and inserts a one-cycle blanking gap between digits to suppress ghosting. It sits between the counter and the board's common-cathode display pins.

## Interface
- DIV, 4: clock cycles per digit slot; legal range 2..65535; frame length = 2*DIV cycles.
- CLK  in  1  system clock; all state changes on rising edge.
- RST  in  1  reset, synchronous, active-high.
- IN1  in  4  ones digit, BCD.
- IN10  in  4  tens digit, BCD.
- BLANK_LZ  in  1  1 = blank the tens digit when it is 0.
- SEG  out  7  segments {g,f,e,d,c,b,a}, active-high.
- DIG  out  2  digit enables, active-high one-hot; bit0 = ones, bit1 = tens; 00 = all off.
- FRAME  out  1  one-cycle pulse marking the last cycle of a frame (shadow load edge).

## Operation
- Registers: cnt (0..DIV-1, width clog2(DIV)), st in {ONES, TENS}, shadow sh1[3:0], sh10[3:0], shlz.
- Per clock with RST=0: if cnt==DIV-1 then cnt<=0 and st toggles (ONES->TENS, TENS->ONES); else cnt<=cnt+1.
- Shadow load: at the edge where cnt==DIV-1 and st==TENS, sh1<=IN1, sh10<=IN10, shlz<=BLANK_LZ. Inputs at any other edge are ignored.
- RST=1 at any edge (including mid-frame): cnt<=0, st<=ONES, sh1<=0, sh10<=0, shlz<=0. Reset dominates shadow load.
- Outputs are combinational decodes of registered state only (no input-to-output paths):
  - cnt==0: DIG=00, SEG=0000000 (gap cycle).
  - cnt!=0, st==ONES: DIG=01, SEG=dec(sh1).
  - cnt!=0, st==TENS: if shlz==1 and sh10==0, DIG=00 and SEG=0000000; else DIG=10, SEG=dec(sh10).
  - FRAME = (st==TENS && cnt==DIV-1).
- dec(): 0->3F, 1->06, 2->5B, 3->4F, 4->66, 5->6D, 6->7D, 7->07, 8->7F, 9->6F (hex, SEG[6:0]); 10..15 -> 40 (dash, g only).
- DIG never has both bits set; SEG is 0000000 whenever DIG==00.

## Timing
- Reset values (during and first cycle after RST): DIG=00, SEG=0000000, FRAME=0.
- Let t=0 be the first cycle after the RST=1 edge. cnt=t mod DIV; st=ONES for t mod 2DIV < DIV, else TENS.
- Frame: gap, DIV-1 ones cycles, gap, DIV-1 tens cycles; period 2*DIV.
- FRAME high at t = 2*DIV*k + 2*DIV-1; shadow updates at the end of that cycle; new values visible from t = 2*DIV*(k+1)+1 (ones) and 2*DIV*(k+1)+DIV+1 (tens).
- Input-to-display latency: 1 to 2*DIV cycles depending on arrival phase; both digits always change in the same frame (no torn 2-digit value).
- First frame after reset displays shadow 00 (ones 3F, tens 3F since shlz=0).
- cnt wrap at DIV-1 and st toggle occur on the same edge; no extra cycles between slots.

## Test plan
- Reset: hold RST=1 for 2 cycles, IN1=7, IN10=4 -> DIG=00, SEG=00, FRAME=0; with DIV=4 after release t=0 DIG=00, t=1..3 DIG=01 SEG=3F, t=4 DIG=00, t=5..7 DIG=10 SEG=3F, FRAME=1 only at t=7.
- Snapshot: continue with IN1=7, IN10=4 -> t=9..11 DIG=01 SEG=07, t=13..15 DIG=10 SEG=66, FRAME at t=15.
- Mid-frame change: change IN1 to 2 at t=18 and back to 7 at t=20 -> display unchanged (07/66) through frame 2; value presented at t=23 appears at t=25.
- Leading-zero blank: IN10=0, IN1=5, BLANK_LZ=1 loaded at a FRAME -> next frame ones DIG=01 SEG=6D, tens slot DIG=00 SEG=00; same with BLANK_LZ=0 -> tens DIG=10 SEG=3F.
- Invalid BCD: IN1=12, IN10=15 -> SEG=40 in both slots, DIG one-hot as normal.
- Reset mid-frame: assert RST at t=6 (TENS, cnt=2) for one cycle -> next cycle DIG=00, cnt restarts at 0 in ONES, following ones slot shows SEG=3F (shadow cleared); drive counter 00..99 sequence and check every frame shows a consistent loaded pair.

Source files
------------

// File: rtl/seg7_scan2.sv
// Two-digit multiplexed 7-seg driver: snapshots BCD digits once per frame,
// scans ones/tens with a blank gap cycle before each digit.
// Ports: CLK, RST (sync, active-high), IN1/IN10 BCD digits, BLANK_LZ,
//        SEG {g..a}, DIG one-hot enables (bit0 ones), FRAME end-of-frame pulse.
module seg7_scan2 #(
  parameter int DIV = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] IN1,
  input  logic [3:0] IN10,
  input  logic       BLANK_LZ,
  output logic [6:0] SEG,
  output logic [1:0] DIG,
  output logic       FRAME
);

  localparam int CW = (DIV <= 2) ? 1 : $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  typedef enum logic {ONES, TENS} st_t;

  st_t           r_st;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_sh1;
  logic [3:0]    r_sh10;
  logic          r_shlz;

  logic          w_wrap;
  logic          w_gap;
  logic          w_lz;
  logic [3:0]    w_digit;

  function automatic logic [6:0] dec(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  assign w_wrap = (r_cnt == LAST);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt  <= '0;
      r_st   <= ONES;
      r_sh1  <= '0;
      r_sh10 <= '0;
      r_shlz <= 1'b0;
    end else begin
      if (w_wrap) begin
        r_cnt <= '0;
        r_st  <= (r_st == ONES) ? TENS : ONES;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      // Both digits captured on one edge so a pair is never torn.
      if (w_wrap && r_st == TENS) begin
        r_sh1  <= IN1;
        r_sh10 <= IN10;
        r_shlz <= BLANK_LZ;
      end
    end
  end

  assign w_gap   = (r_cnt == '0);
  assign w_lz    = r_shlz && (r_sh10 == 4'd0);
  assign w_digit = (r_st == ONES) ? r_sh1 : r_sh10;

  always_comb begin
    DIG = 2'b00;
    SEG = 7'h00;
    if (!w_gap) begin
      if (r_st == ONES) begin
        DIG = 2'b01;
        SEG = dec(w_digit);
      end else if (!w_lz) begin
        DIG = 2'b10;
        SEG = dec(w_digit);
      end
    end
  end

  assign FRAME = (r_st == TENS) && w_wrap;

endmodule

// File: tb/tb_seg7_scan2.sv
// Bench for seg7_scan2: directed scenarios plus random stimulus,
// checked against a frame-phase reference model.
module tb_seg7_scan2;

  localparam int DIV = 4;
  localparam int FR  = 2 * DIV;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] IN1 = '0;
  logic [3:0] IN10 = '0;
  logic       BLANK_LZ = 1'b0;
  logic [6:0] SEG;
  logic [1:0] DIG;
  logic       FRAME;

  int n_chk  = 0;
  int n_fail = 0;

  int         t = 0;
  bit         valid = 0;
  logic [3:0] m1 = '0;
  logic [3:0] m10 = '0;
  logic       mlz = 1'b0;

  seg7_scan2 #(.DIV(DIV)) dut (
    .CLK(CLK), .RST(RST), .IN1(IN1), .IN10(IN10),
    .BLANK_LZ(BLANK_LZ), .SEG(SEG), .DIG(DIG), .FRAME(FRAME)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0d got %h expected %h", tag, t, obs, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] tab [10];
    tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
            7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    return (d > 4'd9) ? 7'h40 : tab[d];
  endfunction

  task automatic step(input logic r, input logic [3:0] a,
                      input logic [3:0] b, input logic z);
    int p;
    logic [1:0] ed;
    logic [6:0] es;
    @(negedge CLK);
    if (valid) begin
      p  = t % FR;
      ed = 2'b00;
      es = 7'h00;
      if (p > 0 && p < DIV) begin
        ed = 2'b01;
        es = seg_of(m1);
      end else if (p > DIV && !(mlz && m10 == 4'd0)) begin
        ed = 2'b10;
        es = seg_of(m10);
      end
      chk("SEG", {1'b0, SEG}, {1'b0, es});
      chk("DIG", {6'b0, DIG}, {6'b0, ed});
      chk("FRAME", {7'b0, FRAME}, {7'b0, p == FR - 1});
    end
    RST = r; IN1 = a; IN10 = b; BLANK_LZ = z;
    if (r) begin
      t = 0; m1 = '0; m10 = '0; mlz = 1'b0; valid = 1;
    end else if (valid) begin
      if (t % FR == FR - 1) begin
        m1 = a; m10 = b; mlz = z;
      end
      t++;
    end
  endtask

  initial begin
    step(1, 4'd7, 4'd4, 0);
    step(1, 4'd7, 4'd4, 0);
    for (int i = 0; i < 16; i++) step(0, 4'd7, 4'd4, 0);
    for (int i = 0; i < 16; i++)
      step(0, (t == 18 || t == 19) ? 4'd2 : 4'd7, 4'd4, 0);
    for (int i = 0; i < 2 * FR; i++) step(0, 4'd5, 4'd0, 1);
    for (int i = 0; i < 2 * FR; i++) step(0, 4'd5, 4'd0, 0);
    for (int i = 0; i < 2 * FR; i++) step(0, 4'd12, 4'd15, 0);
    while (t % FR != 6) step(0, 4'd9, 4'd8, 0);
    step(1, 4'd9, 4'd8, 0);
    for (int i = 0; i < 2 * FR; i++) step(0, 4'd9, 4'd8, 0);
    for (int v = 0; v < 100; v++)
      for (int k = 0; k < 3; k++)
        step(0, 4'(v % 10), 4'(v / 10), v[0]);
    for (int i = 0; i < 2000; i++)
      step(($urandom_range(63) == 0), 4'($urandom), 4'($urandom),
           1'($urandom));
    step(0, 4'd0, 4'd0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
